// File: rtl/writeback_buffer.sv
// Posted-write buffer between a cache and main memory: writes retire into a FIFO and drain
// in the background; read misses bypass queued writes. Define WB_FORWARD_EN to forward read hits.
module writeback_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic [ADDR_WIDTH-1:0]   mem_address,
  input  logic [DATA_WIDTH-1:0]   mem_write_data,
  output logic [DATA_WIDTH-1:0]   mem_read_data,
  output logic                    mem_ready,
  output logic                    dram_read,
  output logic                    dram_write,
  output logic [ADDR_WIDTH-1:0]   dram_address,
  output logic [DATA_WIDTH-1:0]   dram_write_data,
  input  logic [DATA_WIDTH-1:0]   dram_read_data,
  input  logic                    dram_ready,
  output logic [$clog2(DEPTH):0]  wb_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] READ  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]            state;
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];

  logic                  hit;
  logic [PTR_W-1:0]      idx;
`ifdef WB_FORWARD_EN
  logic [DATA_WIDTH-1:0] hit_data;
  logic                  fwd;
`endif
  logic                  req_free;
  logic                  full;
  logic                  enq;
  logic                  deq;
  logic                  rd_pend;
  logic                  read_elig;

  // Scan oldest to newest so the last match is the youngest entry for that address.
  always_comb begin
    hit = 1'b0;
    idx = '0;
`ifdef WB_FORWARD_EN
    hit_data = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if ((CNT_W'(i) < wb_count) && (addr_mem[idx] == mem_address)) begin
        hit = 1'b1;
`ifdef WB_FORWARD_EN
        hit_data = data_mem[idx];
`endif
      end
    end
  end

  // A request is never taken in the cycle its predecessor completes.
  assign req_free  = !mem_ready;
  assign full      = (wb_count == CNT_W'(DEPTH));
  assign enq       = mem_write && req_free && !full;
  assign deq       = (state == DRAIN) && dram_ready;
  assign rd_pend   = mem_read && req_free;
  assign read_elig = rd_pend && !hit && !full;
`ifdef WB_FORWARD_EN
  assign fwd       = rd_pend && hit && (state != READ) && (state != RESP);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      head            <= '0;
      tail            <= '0;
      wb_count        <= '0;
      mem_ready       <= 1'b0;
      mem_read_data   <= '0;
      dram_read       <= 1'b0;
      dram_write      <= 1'b0;
      dram_address    <= '0;
      dram_write_data <= '0;
    end else begin
      mem_ready <= 1'b0;

      if (enq) begin
        addr_mem[tail] <= mem_address;
        data_mem[tail] <= mem_write_data;
        tail           <= tail + PTR_W'(1);
        mem_ready      <= 1'b1;
      end
      if (deq) begin
        head <= head + PTR_W'(1);
      end
      wb_count <= wb_count + CNT_W'(enq) - CNT_W'(deq);

`ifdef WB_FORWARD_EN
      if (fwd) begin
        mem_ready     <= 1'b1;
        mem_read_data <= hit_data;
      end
`endif

      case (state)
        IDLE: begin
          if (read_elig) begin
            state        <= READ;
            dram_read    <= 1'b1;
            dram_address <= mem_address;
          end else if (wb_count != '0) begin
            state           <= DRAIN;
            dram_write      <= 1'b1;
            dram_address    <= addr_mem[head];
            dram_write_data <= data_mem[head];
          end
        end
        DRAIN: begin
          if (dram_ready) begin
            dram_write <= 1'b0;
            state      <= IDLE;
          end
        end
        READ: begin
          if (dram_ready) begin
            dram_read     <= 1'b0;
            mem_read_data <= dram_read_data;
            mem_ready     <= 1'b1;
            state         <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_buffer.sv
// Scoreboard bench for writeback_buffer: cache-side responses and DRAM-side writes are
// checked against queues filled at stimulus time; a small DRAM model answers requests.
module tb_writeback_buffer;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          mem_read = 1'b0;
  logic          mem_write = 1'b0;
  logic [AW-1:0] mem_address = '0;
  logic [DW-1:0] mem_write_data = '0;
  logic [DW-1:0] mem_read_data;
  logic          mem_ready;
  logic          dram_read;
  logic          dram_write;
  logic [AW-1:0] dram_address;
  logic [DW-1:0] dram_write_data;
  logic [DW-1:0] dram_read_data = '0;
  logic          dram_ready = 1'b0;
  logic [2:0]    wb_count;

  always #5 clk = ~clk;

  writeback_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .mem_ready(mem_ready),
    .dram_read(dram_read), .dram_write(dram_write), .dram_address(dram_address),
    .dram_write_data(dram_write_data), .dram_read_data(dram_read_data),
    .dram_ready(dram_ready), .wb_count(wb_count)
  );

  int compared = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct { bit is_rd; logic [DW-1:0] data; } rsp_t;
  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  rsp_t rsp_q[$];
  wr_t  wr_q[$];
  logic [DW-1:0] mem_model [logic [AW-1:0]];

  bit dram_en = 1'b0;
  bit pulse_req = 1'b0;
  bit pulse_raw = 1'b0;
  int dram_lat = 0;
  int wait_cnt = 0;
  int n_wr = 0;
  int n_rd = 0;
  int rd_wr_snap = 0;

  // Cache-side monitor
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (!reset && mem_ready) begin
        if (rsp_q.size() == 0) check("unexpected_mem_ready", 1, 0);
        else begin
          e = rsp_q.pop_front();
          if (e.is_rd) check("mem_read_data", mem_read_data, e.data);
        end
      end
    end
  end

  // DRAM model: answers after dram_lat waiting cycles, or at once on pulse_req
  initial begin
    wr_t w;
    forever begin
      @(negedge clk);
      if (!reset && (dram_read || dram_write))
        check("dram_exclusive", dram_read & dram_write, 0);
      if (dram_ready) dram_ready = 1'b0;
      else if (pulse_raw) begin
        dram_ready = 1'b1;
        pulse_raw = 1'b0;
      end else if ((dram_read || dram_write) && (dram_en || pulse_req)) begin
        if (pulse_req || wait_cnt >= dram_lat) begin
          dram_ready = 1'b1;
          pulse_req = 1'b0;
          wait_cnt = 0;
          if (dram_write) begin
            n_wr++;
            if (wr_q.size() == 0) check("unexpected_dram_write", 1, 0);
            else begin
              w = wr_q.pop_front();
              check("dram_wr_addr", dram_address, w.a);
              check("dram_wr_data", dram_write_data, w.d);
            end
            mem_model[dram_address] = dram_write_data;
          end else begin
            n_rd++;
            rd_wr_snap = n_wr;
            dram_read_data = mem_model.exists(dram_address) ? mem_model[dram_address] : '0;
          end
        end else wait_cnt++;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_req(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [DW-1:0] exp_rd);
    rsp_t e;
    wr_t  w;
    e.is_rd = !wr;
    e.data = exp_rd;
    rsp_q.push_back(e);
    if (wr) begin
      w.a = a;
      w.d = d;
      wr_q.push_back(w);
    end
  endtask

  task automatic do_req(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [DW-1:0] exp_rd, output int lat);
    expect_req(wr, a, d, exp_rd);
    mem_address = a;
    mem_write_data = d;
    mem_write = wr;
    mem_read = !wr;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!mem_ready && lat < 200);
    if (!mem_ready) check("req_timeout", 0, 1);
    mem_write = 1'b0;
    mem_read = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((wb_count != 0 || dram_write || dram_read) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_done_count", wb_count, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n;
    int base_wr;
    int base_rd;

    // Reset state
    reset = 1'b1;
    cyc(2);
    check("rst_mem_ready", mem_ready, 0);
    check("rst_wb_count", wb_count, 0);
    check("rst_dram_read", dram_read, 0);
    check("rst_dram_write", dram_write, 0);
    check("rst_dram_address", dram_address, 0);
    check("rst_mem_read_data", mem_read_data, 0);
    reset = 1'b0;
    cyc(1);

    // Single write then drain
    dram_en = 1'b1;
    dram_lat = 2;
    do_req(1'b1, 32'h100, 32'h11, '0, lat);
    check("wr_latency", lat, 1);
    check("count_after_wr", wb_count, 1);
    n = 0;
    while (!dram_write && n < 20) begin cyc(1); n++; end
    check("drain_addr", dram_address, 32'h100);
    check("drain_data", dram_write_data, 32'h11);
    wait_drain();

    // Full buffer stalls the fifth write until one slot drains
    dram_en = 1'b0;
    for (int i = 0; i < 4; i++)
      do_req(1'b1, 32'h400 + 4 * i, 32'hA0 + i, '0, lat);
    check("full_count", wb_count, 4);
    expect_req(1'b1, 32'h410, 32'hA4, '0);
    mem_address = 32'h410;
    mem_write_data = 32'hA4;
    mem_write = 1'b1;
    cyc(3);
    check("stall_mem_ready", mem_ready, 0);
    check("stall_count", wb_count, 4);
    pulse_req = 1'b1;
    cyc(1);
    check("free_slot_count", wb_count, 3);
    check("no_enq_on_free_cycle", mem_ready, 0);
    cyc(1);
    check("late_enq_ready", mem_ready, 1);
    check("late_enq_count", wb_count, 4);
    mem_write = 1'b0;
    dram_en = 1'b1;
    dram_lat = 1;
    wait_drain();

    // Read of an address with two queued writes
    base_wr = n_wr;
    base_rd = n_rd;
    mem_model[32'h200] = 32'h55;
    dram_en = 1'b0;
    do_req(1'b1, 32'h200, 32'hAA, '0, lat);
    do_req(1'b1, 32'h200, 32'hBB, '0, lat);
    cyc(1);
`ifdef WB_FORWARD_EN
    do_req(1'b0, 32'h200, '0, 32'hBB, lat);
    check("fwd_latency", lat, 1);
    check("fwd_no_dram_read", n_rd - base_rd, 0);
    dram_en = 1'b1;
    dram_lat = 1;
    wait_drain();
    check("fwd_no_dram_read_after", n_rd - base_rd, 0);
`else
    dram_en = 1'b1;
    dram_lat = 1;
    do_req(1'b0, 32'h200, '0, 32'hBB, lat);
    check("read_after_both_drained", rd_wr_snap - base_wr, 2);
    check("hit_read_dram_reads", n_rd - base_rd, 1);
    wait_drain();
`endif

    // Read miss bypasses queued writes
    dram_en = 1'b0;
    mem_model[32'h300] = 32'h5A;
    base_wr = n_wr;
    do_req(1'b1, 32'h310, 32'h31, '0, lat);
    do_req(1'b1, 32'h320, 32'h32, '0, lat);
    cyc(1);
    check("bypass_count", wb_count, 2);
    dram_en = 1'b1;
    dram_lat = 1;
    do_req(1'b0, 32'h300, '0, 32'h5A, lat);
    check("read_bypass_order", rd_wr_snap - base_wr, 1);
    wait_drain();
    check("bypass_writes_done", n_wr - base_wr, 2);

    // Reset in the middle of a drain
    dram_en = 1'b0;
    for (int i = 0; i < 3; i++)
      do_req(1'b1, 32'h600 + 4 * i, 32'h60 + i, '0, lat);
    cyc(1);
    check("pre_rst_count", wb_count, 3);
    check("pre_rst_draining", dram_write, 1);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    wr_q.delete();
    pulse_raw = 1'b1;
    cyc(3);
    check("post_rst_count", wb_count, 0);
    check("post_rst_dram_write", dram_write, 0);
    check("post_rst_dram_read", dram_read, 0);
    check("post_rst_mem_ready", mem_ready, 0);

    // Simultaneous enqueue and dequeue, then continuous traffic across pointer wrap
    base_wr = n_wr;
    do_req(1'b1, 32'h700, 32'h70, '0, lat);
    do_req(1'b1, 32'h704, 32'h71, '0, lat);
    cyc(1);
    check("pre_same_cycle_count", wb_count, 2);
    expect_req(1'b1, 32'h708, 32'h72, '0);
    mem_address = 32'h708;
    mem_write_data = 32'h72;
    mem_write = 1'b1;
    pulse_req = 1'b1;
    cyc(1);
    check("enq_deq_same_cycle_count", wb_count, 2);
    check("enq_deq_same_cycle_ready", mem_ready, 1);
    mem_write = 1'b0;
    dram_en = 1'b1;
    dram_lat = 0;
    for (int i = 0; i < 9; i++)
      do_req(1'b1, 32'h800 + 4 * i, 32'h900 + i, '0, lat);
    wait_drain();
    check("stream_writes_done", n_wr - base_wr, 12);

    cyc(5);
    check("rsp_queue_empty", rsp_q.size(), 0);
    check("wr_queue_empty", wr_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/writeback_buffer.md
WRITEBACK_BUFFER -- requirements
Module: writeback_buffer

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, default 32, data word width; ADDR_WIDTH, default 32, address width; DEPTH, default 4, write-buffer entries (power of 2, >=2).
REQ-002 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 mem_read / mem_write  in  1 each  cache-side request strobes (mutually exclusive), held until mem_ready.
REQ-005 mem_address  in  ADDR_WIDTH  request address; mem_write_data  in  DATA_WIDTH  store data.
REQ-006 mem_read_data  out  DATA_WIDTH  read result, valid while mem_ready=1.
REQ-007 mem_ready  out  1  one-cycle completion pulse to cache.
REQ-008 dram_read / dram_write  out  1 each  main-memory strobes, held until dram_ready.
REQ-009 dram_address  out  ADDR_WIDTH; dram_write_data  out  DATA_WIDTH; dram_read_data  in  DATA_WIDTH; dram_ready  in  1  one-cycle completion pulse.
REQ-010 wb_count  out  $clog2(DEPTH)+1  entries occupied.

Function
REQ-011 SHALL hold a circular FIFO of DEPTH {address, data} entries; head/tail pointers wrap modulo DEPTH.
REQ-012 Request accepted only in a cycle with mem_ready=0; no request is accepted in the mem_ready cycle.
REQ-013 Write with wb_count<DEPTH: enqueue at tail; mem_ready=1 next cycle (1-cycle latency).
REQ-014 Write with wb_count==DEPTH: stall (mem_ready=0) until a drain frees a slot; enqueue same cycle the slot frees is forbidden; enqueue next cycle.
REQ-015 Duplicate-address writes SHALL each occupy an entry; no coalescing.
REQ-016 Read hitting buffer: behaviour per REQ-026/REQ-027.
REQ-017 Read missing buffer: issue dram_read with mem_address; on dram_ready, capture dram_read_data, mem_ready=1 next cycle with that data.
REQ-018 FSM states: IDLE, DRAIN, READ, RESP.
REQ-019 IDLE->READ: pending read miss and wb_count<DEPTH (reads bypass writes).
REQ-020 IDLE->DRAIN: wb_count>0 and no eligible read; drives dram_write, head address/data.
REQ-021 DRAIN->IDLE on dram_ready: dequeue head, wb_count decrements that edge.
REQ-022 READ->RESP on dram_ready; RESP->IDLE unconditionally after one cycle.
REQ-023 Exactly one dram operation outstanding; dram_read and dram_write never both 1; dram_* stable while awaiting dram_ready.
REQ-024 Enqueue and dequeue in same cycle: wb_count unchanged, both pointers advance.
REQ-025 dram_ready outside DRAIN/READ SHALL be ignored.

Reset
REQ-028 reset=1 at a rising edge: FSM->IDLE, pointers and wb_count=0, buffer contents discarded, mem_ready=0, dram_read=0, dram_write=0, mem_read_data=0, dram_address=0, dram_write_data=0 from next cycle.
REQ-029 Reset mid-DRAIN/READ SHALL abandon the operation; a later dram_ready SHALL be ignored (REQ-025).

Configuration
REQ-026 Macro WB_FORWARD_EN defined: read whose address matches any valid entry returns the newest matching entry's data with mem_ready=1 next cycle, no dram access.
REQ-027 WB_FORWARD_EN undefined: read with address match SHALL wait in IDLE/DRAIN until no entry matches, then proceed per REQ-017 (reads memory after drain).

Verification
REQ-030 Reset, then write A=0x100 D=0x11 -> mem_ready pulse next cycle, wb_count=1, then dram_write A=0x100 D=0x11; after dram_ready wb_count=0.
REQ-031 With dram_ready held 0, 5 writes (DEPTH=4) -> 4 accepted, 5th stalls; first dram_ready -> 5th accepted one cycle later, wb_count=4.
REQ-032 Writes 0x200<-0xAA then 0x200<-0xBB, read 0x200 -> WB_FORWARD_EN: 0xBB, 1-cycle latency, no dram_read; undefined: dram_read issued only after both entries drained, memory returns 0xBB.
REQ-033 Buffer holds 2 entries, read miss 0x300 with memory data 0x5A -> dram_read issued before further drains; mem_read_data=0x5A in RESP cycle.
REQ-034 Assert reset during DRAIN with 3 entries, then pulse dram_ready -> wb_count=0, dram_write=0, no mem_ready pulse.
REQ-035 Fill/drain 9 writes continuously -> pointers wrap, data written to memory in order, enqueue+dequeue same cycle leaves wb_count unchanged.
